// File: rtl/cdb_host_if.sv
// -----------------------------------------------------------------------------
// cdb_host_if
// CD-block host interface on the SCU A-bus (CS2 area). Provides the HIRQ /
// HIRQMASK interrupt flags, NUM_CR command/response register pairs, a command
// handshake FSM toward the CD-block core, and a DEPTH-word data FIFO that the
// host drains through the DATATRNS register.
//
// Ports
//   CLK, RST_N, CE_R       clock, async active-low reset, clock enable
//   AA, ADI, ADO           A-bus address, write data, read data (combinational)
//   ACS2_N, ARD_N          chip select and read strobe
//   AWRU_N, AWRL_N         upper / lower byte write strobes
//   IRQ_N                  registered host interrupt, active-low
//   CMD_VALID/READY/DATA   command handshake toward the CD core
//   RESP_WE, RESP_DATA     response set load from the CD core
//   HIRQ_SET               per-bit HIRQ set pulses from the CD core
//   FIFO_WE, FIFO_D        data push from the CD core
//   FIFO_FULL, FIFO_CNT    FIFO status
//
// Register map (byte offset inside the window)
//   0x00 DATATRNS (RO)  0x08 HIRQ  0x0C HIRQMASK  0x18+4k CRk
// -----------------------------------------------------------------------------
module cdb_host_if #(
  parameter logic [9:0]  BASE_HI  = 10'h189,
  parameter int          NUM_CR   = 4,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] HIRQ_RST = 16'hFFFF
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CE_R,
  input  logic [25:0]                AA,
  input  logic [15:0]                ADI,
  output logic [15:0]                ADO,
  input  logic                       ACS2_N,
  input  logic                       ARD_N,
  input  logic                       AWRU_N,
  input  logic                       AWRL_N,
  output logic                       IRQ_N,
  output logic                       CMD_VALID,
  input  logic                       CMD_READY,
  output logic [16*NUM_CR-1:0]       CMD_DATA,
  input  logic                       RESP_WE,
  input  logic [16*NUM_CR-1:0]       RESP_DATA,
  input  logic [15:0]                HIRQ_SET,
  input  logic                       FIFO_WE,
  input  logic [15:0]                FIFO_D,
  output logic                       FIFO_FULL,
  output logic [$clog2(DEPTH):0]     FIFO_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0] OFF_DATA = 16'h0000;
  localparam logic [15:0] OFF_HIRQ = 16'h0008;
  localparam logic [15:0] OFF_MASK = 16'h000C;
  localparam logic [15:0] OFF_CR0  = 16'h0018;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  // Byte offset of command/response register k.
  function automatic logic [15:0] cr_off(input int k);
    cr_off = OFF_CR0 + 16'(4 * k);
  endfunction

  // Power-up contents of response register k ("CDBLOCK" signature in CR0..CR3).
  function automatic logic [15:0] resp_rst(input int k);
    case (k)
      0:       resp_rst = 16'h0043;
      1:       resp_rst = 16'h4442;
      2:       resp_rst = 16'h4C4F;
      3:       resp_rst = 16'h434B;
      default: resp_rst = 16'h0000;
    endcase
  endfunction

  // Replace only the bytes whose lane mask is set.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [15:0] lane);
    lane_merge = (old_v & ~lane) | (new_v & lane);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic            r_cmd_valid;
  logic [15:0]     r_cmd  [NUM_CR];
  logic [15:0]     r_resp [NUM_CR];
  logic [15:0]     r_hirq;
  logic [15:0]     r_mask;
  logic            r_irq_n;
  logic            r_wr_prev;
  logic            r_rd_prev;
  logic [15:0]     r_mem  [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t          w_state_nxt;
  logic            w_sel;
  logic [15:0]     w_off;
  logic            w_wr_n;
  logic            w_wr_stb;
  logic [15:0]     w_lane;
  logic [NUM_CR-1:0] w_cr_hit;
  logic            w_cr_wr_en;
  logic            w_last_wr;
  logic [15:0]     w_hirq_nxt;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [15:0]     w_ado;
  logic            w_unused_a0;

  assign w_sel       = !ACS2_N && (AA[25:16] == BASE_HI);
  assign w_off       = {AA[15:1], 1'b0};
  assign w_unused_a0 = AA[0];
  assign w_wr_n      = AWRU_N & AWRL_N;
  // One write per strobe: only the CE_R cycle where the combined strobe falls.
  assign w_wr_stb    = CE_R && w_sel && r_wr_prev && !w_wr_n;
  assign w_lane      = {{8{!AWRU_N}}, {8{!AWRL_N}}};
  // CR writes are frozen while the core is executing a command.
  assign w_cr_wr_en  = w_wr_stb && (r_state != ST_BUSY);
  assign w_last_wr   = w_wr_stb && (w_off == cr_off(NUM_CR - 1));

  assign w_empty = (r_cnt == {CW{1'b0}});
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_push  = CE_R && FIFO_WE && !w_full;
  // Pop at the end of a DATATRNS read access (ARD_N rising).
  assign w_pop   = CE_R && w_sel && (w_off == OFF_DATA) && !r_rd_prev && ARD_N && !w_empty;

  // Decode which CR offset is addressed.
  always_comb begin
    w_cr_hit = {NUM_CR{1'b0}};
    for (int k = 0; k < NUM_CR; k++) begin
      if (w_off == cr_off(k)) begin
        w_cr_hit[k] = 1'b1;
      end else begin
        w_cr_hit[k] = 1'b0;
      end
    end
  end

  // Command FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_last_wr) w_state_nxt = ST_PEND;
        else           w_state_nxt = ST_IDLE;
      end
      ST_PEND: begin
        if (CMD_READY) w_state_nxt = ST_BUSY;
        else           w_state_nxt = ST_PEND;
      end
      ST_BUSY: begin
        if (RESP_WE)   w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_BUSY;
      end
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // Command FSM state register; CMD_VALID is registered from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
    end else if (CE_R) begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == ST_PEND);
    end
  end

  // Command registers written by the host.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_CR; k++) r_cmd[k] <= 16'h0000;
    end else begin
      for (int k = 0; k < NUM_CR; k++) begin
        if (w_cr_wr_en && w_cr_hit[k]) r_cmd[k] <= lane_merge(r_cmd[k], ADI, w_lane);
      end
    end
  end

  // Response registers loaded by the CD core in any FSM state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_CR; k++) r_resp[k] <= resp_rst(k);
    end else if (CE_R && RESP_WE) begin
      for (int k = 0; k < NUM_CR; k++) r_resp[k] <= RESP_DATA[16*k +: 16];
    end
  end

  // HIRQ next value: host write clears bits, then core set pulses and CMOK win.
  always_comb begin
    w_hirq_nxt = r_hirq;
    if (w_wr_stb && (w_off == OFF_HIRQ)) begin
      w_hirq_nxt = r_hirq & (ADI | ~w_lane);
    end else begin
      w_hirq_nxt = r_hirq;
    end
    w_hirq_nxt = w_hirq_nxt | HIRQ_SET | {15'b0, RESP_WE};
  end

  // HIRQ, HIRQMASK and interrupt output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hirq  <= HIRQ_RST;
      r_mask  <= 16'h0000;
      r_irq_n <= 1'b1;
    end else if (CE_R) begin
      r_hirq  <= w_hirq_nxt;
      if (w_wr_stb && (w_off == OFF_MASK)) r_mask <= lane_merge(r_mask, ADI, w_lane);
      r_irq_n <= ~|(r_hirq & r_mask);
    end
  end

  // Strobe history for write-fall and read-rise detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_prev <= 1'b1;
      r_rd_prev <= 1'b1;
    end else if (CE_R) begin
      r_wr_prev <= w_wr_n;
      r_rd_prev <= ARD_N;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= FIFO_D;
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
      r_cnt  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Host read mux; unmapped offsets and deselected cycles return zero.
  always_comb begin
    w_ado = 16'h0000;
    if (!w_sel) begin
      w_ado = 16'h0000;
    end else if (w_off == OFF_DATA) begin
      w_ado = w_empty ? 16'h0000 : r_mem[r_rptr];
    end else if (w_off == OFF_HIRQ) begin
      w_ado = r_hirq;
    end else if (w_off == OFF_MASK) begin
      w_ado = r_mask;
    end else begin
      for (int k = 0; k < NUM_CR; k++) begin
        if (w_cr_hit[k]) w_ado = r_resp[k];
      end
    end
  end

  // Flatten command registers, CR0 in the LSBs.
  always_comb begin
    CMD_DATA = '0;
    for (int k = 0; k < NUM_CR; k++) CMD_DATA[16*k +: 16] = r_cmd[k];
  end

  assign ADO       = w_ado;
  assign IRQ_N     = r_irq_n;
  assign CMD_VALID = r_cmd_valid;
  assign FIFO_FULL = w_full;
  assign FIFO_CNT  = r_cnt;

endmodule

// File: tb/tb_cdb_host_if.sv
// -----------------------------------------------------------------------------
// tb_cdb_host_if
// Directed bench for cdb_host_if. Stimulus tasks push expected values into a
// scoreboard queue; an independent monitor pops and compares them as the DUT
// presents read data or settled status outputs.
// -----------------------------------------------------------------------------
module tb_cdb_host_if;

  localparam int NUM_CR = 4;
  localparam int DEPTH  = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b1;
  logic [25:0] AA = 26'h0;
  logic [15:0] ADI = 16'h0;
  logic [15:0] ADO;
  logic        ACS2_N = 1'b1;
  logic        ARD_N = 1'b1;
  logic        AWRU_N = 1'b1;
  logic        AWRL_N = 1'b1;
  logic        IRQ_N;
  logic        CMD_VALID;
  logic        CMD_READY = 1'b0;
  logic [63:0] CMD_DATA;
  logic        RESP_WE = 1'b0;
  logic [63:0] RESP_DATA = 64'h0;
  logic [15:0] HIRQ_SET = 16'h0;
  logic        FIFO_WE = 1'b0;
  logic [15:0] FIFO_D = 16'h0;
  logic        FIFO_FULL;
  logic [4:0]  FIFO_CNT;

  cdb_host_if #(
    .BASE_HI(10'h189), .NUM_CR(NUM_CR), .DEPTH(DEPTH), .HIRQ_RST(16'hFFFF)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .AA(AA), .ADI(ADI), .ADO(ADO),
    .ACS2_N(ACS2_N), .ARD_N(ARD_N), .AWRU_N(AWRU_N), .AWRL_N(AWRL_N),
    .IRQ_N(IRQ_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DATA(CMD_DATA), .RESP_WE(RESP_WE), .RESP_DATA(RESP_DATA),
    .HIRQ_SET(HIRQ_SET), .FIFO_WE(FIFO_WE), .FIFO_D(FIFO_D),
    .FIFO_FULL(FIFO_FULL), .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_RD, K_IRQ, K_VALID, K_CMDD, K_CNT, K_FULL} kind_t;
  typedef struct {
    kind_t       kind;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: read data is compared on the first sample of each read strobe,
  // status expectations on the first sample after they are queued.
  initial begin : monitor
    logic        rd_prev;
    logic        rd_start;
    logic [63:0] act;
    exp_t        e;
    rd_prev = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      rd_start = !ACS2_N && !ARD_N && rd_prev;
      while (q.size() > 0) begin
        e = q[0];
        if (e.kind == K_RD && !rd_start) break;
        case (e.kind)
          K_RD:    begin act = {48'h0, ADO}; rd_start = 1'b0; end
          K_IRQ:   act = {63'h0, IRQ_N};
          K_VALID: act = {63'h0, CMD_VALID};
          K_CMDD:  act = CMD_DATA;
          K_CNT:   act = {59'h0, FIFO_CNT};
          default: act = {63'h0, FIFO_FULL};
        endcase
        void'(q.pop_front());
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
      rd_prev = ARD_N;
    end
  end

  task automatic bus_write(input logic [15:0] off, input logic [15:0] d,
                           input logic up, input logic lo, input logic [15:0] set);
    @(negedge CLK);
    AA = {10'h189, off}; ADI = d; ACS2_N = 1'b0;
    AWRU_N = !up; AWRL_N = !lo; HIRQ_SET = set;
    @(negedge CLK);
    AWRU_N = 1'b1; AWRL_N = 1'b1; HIRQ_SET = 16'h0;
    @(negedge CLK);
    ACS2_N = 1'b1;
  endtask

  task automatic wr(input logic [15:0] off, input logic [15:0] d);
    bus_write(off, d, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic bus_read(input logic [15:0] off, input logic [15:0] e, input string nm,
                          input logic push, input logic [15:0] pd);
    @(negedge CLK);
    AA = {10'h189, off}; ACS2_N = 1'b0; ARD_N = 1'b0;
    q.push_back('{K_RD, {48'h0, e}, nm});
    @(negedge CLK);
    ARD_N = 1'b1; FIFO_WE = push; FIFO_D = pd;
    @(negedge CLK);
    ACS2_N = 1'b1; FIFO_WE = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, input logic [15:0] e, input string nm);
    bus_read(off, e, nm, 1'b0, 16'h0);
  endtask

  task automatic expect_sig(input kind_t k, input logic [63:0] v, input string nm);
    @(negedge CLK);
    q.push_back('{k, v, nm});
  endtask

  task automatic fifo_push(input logic [15:0] d);
    @(negedge CLK);
    FIFO_WE = 1'b1; FIFO_D = d;
    @(negedge CLK);
    FIFO_WE = 1'b0;
  endtask

  logic [15:0] resp_rst_tbl [4] = '{16'h0043, 16'h4442, 16'h4C4F, 16'h434B};

  initial begin : stim
    int wait_cnt;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Reset state
    for (int k = 0; k < 4; k++) rd(16'h0018 + 16'(4 * k), resp_rst_tbl[k], "rst_resp");
    rd(16'h0008, 16'hFFFF, "rst_hirq");
    rd(16'h000C, 16'h0000, "rst_mask");
    rd(16'h0004, 16'h0000, "unmapped");
    rd(16'h0000, 16'h0000, "rst_datatrns");
    expect_sig(K_IRQ,   64'd1, "rst_irq_n");
    expect_sig(K_VALID, 64'd0, "rst_cmd_valid");
    expect_sig(K_CNT,   64'd0, "rst_fifo_cnt");
    expect_sig(K_FULL,  64'd0, "rst_fifo_full");

    // Command handshake
    wr(16'h0008, 16'h0000);
    rd(16'h0008, 16'h0000, "hirq_clear");
    wr(16'h0018, 16'h0001);
    wr(16'h001C, 16'h0002);
    wr(16'h0020, 16'h0003);
    expect_sig(K_VALID, 64'd0, "valid_before_last");
    wr(16'h0024, 16'h0004);
    expect_sig(K_VALID, 64'd1, "valid_pend");
    expect_sig(K_CMDD, 64'h0004_0003_0002_0001, "cmd_data");
    wr(16'h0018, 16'h0005);
    expect_sig(K_CMDD, 64'h0004_0003_0002_0005, "cmd_data_pend_wr");
    @(negedge CLK); CMD_READY = 1'b1;
    @(negedge CLK); CMD_READY = 1'b0;
    expect_sig(K_VALID, 64'd0, "valid_busy");
    wr(16'h0018, 16'h0009);
    wr(16'h0024, 16'h0008);
    expect_sig(K_CMDD, 64'h0004_0003_0002_0005, "cmd_busy_ignored");
    expect_sig(K_VALID, 64'd0, "valid_busy_hold");
    @(negedge CLK); RESP_WE = 1'b1; RESP_DATA = 64'hFEDC_1234_5555_AAAA;
    @(negedge CLK); RESP_WE = 1'b0;
    rd(16'h0018, 16'hAAAA, "resp_cr0");
    rd(16'h001C, 16'h5555, "resp_cr1");
    rd(16'h0020, 16'h1234, "resp_cr2");
    rd(16'h0024, 16'hFEDC, "resp_cr3");
    rd(16'h0008, 16'h0001, "hirq_cmok");
    wr(16'h0018, 16'h0007);
    expect_sig(K_CMDD, 64'h0004_0003_0002_0007, "cmd_idle_wr");
    expect_sig(K_VALID, 64'd0, "valid_idle");
    bus_write(16'h001C, 16'hABCD, 1'b1, 1'b0, 16'h0);
    expect_sig(K_CMDD, 64'h0004_0003_AB02_0007, "cmd_upper_lane");

    // HIRQ / HIRQMASK / IRQ_N
    bus_write(16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF);
    rd(16'h0008, 16'hFFFF, "hirq_set_all");
    wr(16'h0008, 16'hFFFE);
    rd(16'h0008, 16'hFFFE, "hirq_and");
    bus_write(16'h0008, 16'h00F0, 1'b0, 1'b1, 16'h0);
    rd(16'h0008, 16'hFFF0, "hirq_lower_lane");
    wr(16'h000C, 16'h0001);
    rd(16'h000C, 16'h0001, "mask_rw");
    expect_sig(K_IRQ, 64'd1, "irq_masked_off");
    bus_write(16'h0008, 16'h0000, 1'b1, 1'b1, 16'h0001);
    expect_sig(K_IRQ, 64'd0, "irq_asserted");
    rd(16'h0008, 16'h0001, "hirq_set_wins");
    wr(16'h0008, 16'h0000);
    rd(16'h0008, 16'h0000, "hirq_cleared");
    expect_sig(K_IRQ, 64'd1, "irq_released");

    // FIFO fill, overflow, drain, underflow
    for (int i = 0; i < 16; i++) fifo_push(16'(i));
    expect_sig(K_FULL, 64'd1, "fifo_full");
    expect_sig(K_CNT, 64'd16, "fifo_cnt_full");
    fifo_push(16'h00EE);
    expect_sig(K_CNT, 64'd16, "fifo_overflow_drop");
    for (int i = 0; i < 16; i++) rd(16'h0000, 16'(i), "fifo_data");
    rd(16'h0000, 16'h0000, "fifo_empty_read");
    expect_sig(K_CNT, 64'd0, "fifo_cnt_empty");
    expect_sig(K_FULL, 64'd0, "fifo_not_full");

    // Simultaneous push/pop across pointer wrap
    for (int i = 0; i < 12; i++) fifo_push(16'h0100 + 16'(i));
    for (int i = 0; i < 10; i++) rd(16'h0000, 16'h0100 + 16'(i), "wrap_pre");
    for (int i = 12; i < 15; i++) fifo_push(16'h0100 + 16'(i));
    expect_sig(K_CNT, 64'd5, "wrap_cnt5");
    bus_read(16'h0000, 16'h010A, "pushpop_a", 1'b1, 16'h010F);
    expect_sig(K_CNT, 64'd5, "pushpop_cnt_a");
    bus_read(16'h0000, 16'h010B, "pushpop_b", 1'b1, 16'h0110);
    expect_sig(K_CNT, 64'd5, "pushpop_cnt_b");
    for (int i = 12; i < 17; i++) rd(16'h0000, 16'h0100 + 16'(i), "wrap_data");
    expect_sig(K_CNT, 64'd0, "wrap_cnt0");

    // Asynchronous reset mid-command with data in the FIFO
    wr(16'h0024, 16'h0011);
    for (int i = 0; i < 3; i++) fifo_push(16'h0200 + 16'(i));
    expect_sig(K_VALID, 64'd1, "pre_rst_valid");
    expect_sig(K_CNT, 64'd3, "pre_rst_cnt");
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    q.push_back('{K_VALID, 64'd0, "rst_mid_valid"});
    q.push_back('{K_CNT, 64'd0, "rst_mid_cnt"});
    q.push_back('{K_CMDD, 64'd0, "rst_mid_cmd"});
    rd(16'h0008, 16'hFFFF, "rst_mid_hirq");
    rd(16'h0018, 16'h0043, "rst_mid_resp");
    expect_sig(K_IRQ, 64'd1, "rst_mid_irq");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 50) begin
      @(negedge CLK);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
